// File: rtl/alu.sv
// alu: registered ALU with start-qualified capture, status flags and done pulse
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    input  logic [2:0]       alu_ctr,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_bit,
    output logic             carry_out,
    output logic             overflow,
    output logic             done
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic             use_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] res_next;
    logic             c_next;
    logic             v_next;

    // shared adder: SUB, SLT and SLTU all run A + ~B + 1 so compares reuse the subtract carry/overflow
    always_comb begin
        use_sub  = (alu_ctr == OP_SUB) || (alu_ctr == OP_SLT) || (alu_ctr == OP_SLTU);
        b_op     = use_sub ? ~alu_src2 : alu_src2;
        sum      = {1'b0, alu_src1} + {1'b0, b_op} + {{WIDTH{1'b0}}, use_sub};
        add_ovf  = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) && (sum[WIDTH-1] != alu_src1[WIDTH-1]);
        sub_ovf  = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) && (sum[WIDTH-1] != alu_src1[WIDTH-1]);
        res_next = '0;
        case (alu_ctr)
            OP_AND:  res_next = alu_src1 & alu_src2;
            OP_OR:   res_next = alu_src1 | alu_src2;
            OP_ADD:  res_next = sum[WIDTH-1:0];
            OP_XOR:  res_next = alu_src1 ^ alu_src2;
            OP_NOR:  res_next = ~(alu_src1 | alu_src2);
            OP_SLTU: res_next = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            OP_SUB:  res_next = sum[WIDTH-1:0];
            default: res_next = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sub_ovf};
        endcase
        c_next = ((alu_ctr == OP_ADD) || (alu_ctr == OP_SUB)) ? sum[WIDTH] : 1'b0;
        v_next = (alu_ctr == OP_ADD) ? add_ovf : (alu_ctr == OP_SUB) ? sub_ovf : 1'b0;
    end

    // capture on start, hold otherwise; reset wins over start
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_result <= '0;
            zero_bit   <= 1'b1;
            carry_out  <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else if (start) begin
            alu_result <= res_next;
            zero_bit   <= (res_next == '0);
            carry_out  <= c_next;
            overflow   <= v_next;
            done       <= 1'b1;
        end else begin
            done       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for the registered ALU
module tb_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  ctr = '0;
    logic [31:0] alu_result;
    logic        zero_bit;
    logic        carry_out;
    logic        overflow;
    logic        done;
    logic [35:0] got;
    int          errors = 0;
    int          checks = 0;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .alu_src1(a), .alu_src2(b), .alu_ctr(ctr),
        .alu_result(alu_result), .zero_bit(zero_bit),
        .carry_out(carry_out), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    assign got = {alu_result, zero_bit, carry_out, overflow, done};

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        @(negedge clk);
        a = x; b = y; ctr = op; start = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b1; a = 32'd5; b = 32'd3; ctr = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (got !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset got=%h exp=%h", got, {32'h0, 4'b1000});
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
    endtask

    task automatic test_sub();
        issue(32'd2, 32'd2, 3'b110);
        checks++;
        if (got !== {32'h0, 4'b1101}) begin errors++; $display("FAIL sub_zero got=%h exp=%h", got, {32'h0, 4'b1101}); end
        issue(32'd1, 32'd0, 3'b110);
        checks++;
        if (got !== {32'h1, 4'b0101}) begin errors++; $display("FAIL sub_1_0 got=%h exp=%h", got, {32'h1, 4'b0101}); end
        issue(32'd0, 32'd1, 3'b110);
        checks++;
        if (got !== {32'hFFFFFFFF, 4'b0001}) begin errors++; $display("FAIL sub_0_1 got=%h exp=%h", got, {32'hFFFFFFFF, 4'b0001}); end
        issue(32'h80000000, 32'd1, 3'b110);
        checks++;
        if (got !== {32'h7FFFFFFF, 4'b0111}) begin errors++; $display("FAIL sub_ovf got=%h exp=%h", got, {32'h7FFFFFFF, 4'b0111}); end
    endtask

    task automatic test_add();
        issue(32'h7FFFFFFF, 32'd1, 3'b010);
        checks++;
        if (got !== {32'h80000000, 4'b0011}) begin errors++; $display("FAIL add_ovf got=%h exp=%h", got, {32'h80000000, 4'b0011}); end
        issue(32'hFFFFFFFF, 32'd1, 3'b010);
        checks++;
        if (got !== {32'h0, 4'b1101}) begin errors++; $display("FAIL add_carry got=%h exp=%h", got, {32'h0, 4'b1101}); end
        issue(32'd3, 32'd4, 3'b010);
        checks++;
        if (got !== {32'h7, 4'b0001}) begin errors++; $display("FAIL add_plain got=%h exp=%h", got, {32'h7, 4'b0001}); end
    endtask

    task automatic test_compare();
        issue(32'h80000000, 32'd1, 3'b111);
        checks++;
        if (got !== {32'h1, 4'b0001}) begin errors++; $display("FAIL slt_min got=%h exp=%h", got, {32'h1, 4'b0001}); end
        issue(32'h80000000, 32'd1, 3'b101);
        checks++;
        if (got !== {32'h0, 4'b1001}) begin errors++; $display("FAIL sltu_min got=%h exp=%h", got, {32'h0, 4'b1001}); end
        issue(32'd1, 32'h80000000, 3'b111);
        checks++;
        if (got !== {32'h0, 4'b1001}) begin errors++; $display("FAIL slt_rev got=%h exp=%h", got, {32'h0, 4'b1001}); end
        issue(32'hFFFFFFFF, 32'd0, 3'b111);
        checks++;
        if (got !== {32'h1, 4'b0001}) begin errors++; $display("FAIL slt_neg1 got=%h exp=%h", got, {32'h1, 4'b0001}); end
        issue(32'd1, 32'd2, 3'b101);
        checks++;
        if (got !== {32'h1, 4'b0001}) begin errors++; $display("FAIL sltu_lt got=%h exp=%h", got, {32'h1, 4'b0001}); end
    endtask

    task automatic test_logic();
        issue(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000);
        checks++;
        if (got !== {32'h00F000F0, 4'b0001}) begin errors++; $display("FAIL and got=%h exp=%h", got, {32'h00F000F0, 4'b0001}); end
        issue(32'hF0F0F0F0, 32'h0FF00FF0, 3'b001);
        checks++;
        if (got !== {32'hFFF0FFF0, 4'b0001}) begin errors++; $display("FAIL or got=%h exp=%h", got, {32'hFFF0FFF0, 4'b0001}); end
        issue(32'hF0F0F0F0, 32'h0FF00FF0, 3'b011);
        checks++;
        if (got !== {32'hFF00FF00, 4'b0001}) begin errors++; $display("FAIL xor got=%h exp=%h", got, {32'hFF00FF00, 4'b0001}); end
        issue(32'hF0F0F0F0, 32'h0FF00FF0, 3'b100);
        checks++;
        if (got !== {32'h000F000F, 4'b0001}) begin errors++; $display("FAIL nor got=%h exp=%h", got, {32'h000F000F, 4'b0001}); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        start = 1'b0; a = 32'hFFFFFFFF; b = 32'h1; ctr = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (got !== {32'h000F000F, 4'b0000}) begin errors++; $display("FAIL hold1 got=%h exp=%h", got, {32'h000F000F, 4'b0000}); end
        @(negedge clk);
        a = 32'h0; b = 32'h0; ctr = 3'b110;
        @(posedge clk);
        #1;
        checks++;
        if (got !== {32'h000F000F, 4'b0000}) begin errors++; $display("FAIL hold2 got=%h exp=%h", got, {32'h000F000F, 4'b0000}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b0;
        issue(32'd10, 32'd20, 3'b010);
        checks++;
        if (got !== {32'd30, 4'b0001}) begin errors++; $display("FAIL b2b_first got=%h exp=%h", got, {32'd30, 4'b0001}); end
        issue(32'd10, 32'd10, 3'b110);
        checks++;
        if (got !== {32'h0, 4'b1101}) begin errors++; $display("FAIL b2b_second got=%h exp=%h", got, {32'h0, 4'b1101}); end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (got !== {32'h0, 4'b1100}) begin errors++; $display("FAIL b2b_done_drop got=%h exp=%h", got, {32'h0, 4'b1100}); end
    endtask

    task automatic test_reset_mid();
        issue(32'd9, 32'd6, 3'b001);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; a = 32'd1; b = 32'd1; ctr = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (got !== {32'h0, 4'b1000}) begin errors++; $display("FAIL reset_prio got=%h exp=%h", got, {32'h0, 4'b1000}); end
        issue(32'd3, 32'd4, 3'b010);
        checks++;
        if (got !== {32'h7, 4'b0001}) begin errors++; $display("FAIL post_reset got=%h exp=%h", got, {32'h7, 4'b0001}); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_add();
        test_compare();
        test_logic();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
